// File: rtl/pulse_arbiter.sv
// Button-edge arbiter: sync -> optional debounce -> rising-edge detect -> pending flags,
// round-robin granted to one consumer. Define PULSE_ARBITER_DEBOUNCE_EN to add the debounce filter.
module pulse_arbiter #(
  parameter int NREQ      = 4,
  parameter int DB_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         bi,
  output logic                    bo,
  output logic [$clog2(NREQ)-1:0] bo_id,
  input  logic                    bo_ready,
  output logic [NREQ-1:0]         pend,
  output logic                    ovf,
  input  logic                    ovf_clr
);
  localparam int IDW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || DB_CYCLES < 1 || DB_CYCLES > 255) begin : g_param_chk
    $error("pulse_arbiter: parameter out of range");
  end

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   s1_q, s2_q, filt, prev_q, edge_det, clr;
  logic [NREQ-1:0]   pend_q, pend_d;
  logic              ovf_q, ovf_d, ovf_set;
  logic [IDW-1:0]    bo_id_q, last_id_q, pick, idx;
  logic              found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= bi;
      s2_q   <= s1_q;
      prev_q <= filt;
    end
  end

`ifdef PULSE_ARBITER_DEBOUNCE_EN
  // Filtered level flips only after the synced level has disagreed for DB_CYCLES clocks.
  logic [NREQ-1:0]      filt_q;
  logic [NREQ-1:0][7:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (s2_q[i] != filt_q[i]) begin
          if (cnt_q[i] == 8'(DB_CYCLES - 1)) begin
            filt_q[i] <= s2_q[i];
            cnt_q[i]  <= '0;
          end else begin
            cnt_q[i]  <= cnt_q[i] + 8'd1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  assign filt = filt_q;
`else
  assign filt = s2_q;
`endif

  assign edge_det = filt & ~prev_q;
  assign clr      = (state_q == GRANT && bo_ready) ? (NREQ'(1) << bo_id_q) : '0;
  // Set beats the handshake clear for the same requester.
  assign pend_d   = (pend_q & ~clr) | edge_det;
  assign ovf_set  = |(edge_det & pend_q & ~clr);
  assign ovf_d    = ovf_set | (ovf_q & ~ovf_clr);

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    pick  = last_id_q;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last_id_q) + k) % NREQ);
      if (!found && pend_q[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      ovf_q     <= 1'b0;
      bo_id_q   <= '0;
      last_id_q <= IDW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      if (state_q == IDLE && |pend_q) bo_id_q <= pick;
      if (state_q == GRANT && bo_ready) last_id_q <= bo_id_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|pend_q)  state_d = GRANT;
      GRANT:   if (bo_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bo = (state_q == GRANT);
  end

  assign bo_id = bo_id_q;
  assign pend  = pend_q;
  assign ovf   = ovf_q;
endmodule

// File: tb/tb_pulse_arbiter.sv
// Directed bench for pulse_arbiter (NREQ=4); the debounce scenario runs when
// PULSE_ARBITER_DEBOUNCE_EN is defined, the plain-path scenarios otherwise.
module tb_pulse_arbiter;
  localparam int NREQ = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] bi;
  logic       bo;
  logic [1:0] bo_id;
  logic       bo_ready;
  logic [3:0] pend;
  logic       ovf;
  logic       ovf_clr;

  int n_chk  = 0;
  int n_pass = 0;
  int ngr;

  pulse_arbiter #(.NREQ(NREQ), .DB_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .bi(bi), .bo(bo), .bo_id(bo_id), .bo_ready(bo_ready),
    .pend(pend), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one rising edge; inputs driven / outputs sampled 1 time unit after it.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bi = '0; bo_ready = 1'b0; ovf_clr = 1'b0;
    #3;
    chk("rst_bo", 32'(bo), 0);
    chk("rst_bo_id", 32'(bo_id), 0);
    chk("rst_pend", 32'(pend), 0);
    chk("rst_ovf", 32'(ovf), 0);
    tick(2);
    rst = 1'b0;
    tick(1);

`ifdef PULSE_ARBITER_DEBOUNCE_EN
    // 3-cycle glitch never survives the 4-cycle filter.
    bi = 4'b0001; tick(3); bi = '0;
    ngr = 0;
    repeat (12) begin tick(1); if (pend[0] || bo) ngr++; end
    chk("db_glitch", 32'(ngr), 0);
    bi = 4'b0001;
    tick(6);
    chk("db_pend_e6", 32'(pend), 32'h0);
    tick(1);
    chk("db_pend_e7", 32'(pend), 32'h1);
    bi = '0;
`else
    // Single press: pend at edge 3, one-cycle grant at edge 4, exactly one grant.
    bo_ready = 1'b1;
    bi = 4'b0001;
    tick(2);
    chk("sp_pend_e2", 32'(pend), 32'h0);
    tick(1);
    chk("sp_pend_e3", 32'(pend), 32'h1);
    chk("sp_bo_e3", 32'(bo), 0);
    tick(1);
    chk("sp_bo_e4", 32'(bo), 1);
    chk("sp_id_e4", 32'(bo_id), 0);
    tick(1);
    chk("sp_bo_e5", 32'(bo), 0);
    chk("sp_pend_e5", 32'(pend), 0);
    ngr = 0;
    repeat (6) begin tick(1); if (bo) ngr++; end
    chk("sp_extra_grants", 32'(ngr), 0);
    bi = '0;
    tick(4);

    // Round robin from reset: 0,1,2,3 with an idle cycle between grants.
    do_reset();
    bo_ready = 1'b1;
    bi = 4'b1111;
    tick(3);
    chk("rr_pend", 32'(pend), 32'hF);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk($sformatf("rr_bo%0d", k), 32'(bo), 1);
      chk($sformatf("rr_id%0d", k), 32'(bo_id), 32'(k));
      tick(1);
      chk($sformatf("rr_gap%0d", k), 32'(bo), 0);
    end
    chk("rr_pend_end", 32'(pend), 0);
    bi = '0;
    tick(4);

    // Backpressure: grant to 2 held stable for 6 cycles.
    bo_ready = 1'b0;
    bi = 4'b0100;
    tick(1);
    bi = '0;
    tick(3);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("bp_bo%0d", k), 32'(bo), 1);
      chk($sformatf("bp_id%0d", k), 32'(bo_id), 2);
      chk($sformatf("bp_pend%0d", k), 32'(pend), 32'h4);
      if (k < 5) tick(1);
    end
    bo_ready = 1'b1;
    tick(1);
    chk("bp_bo_done", 32'(bo), 0);
    chk("bp_pend_done", 32'(pend), 0);
    tick(2);

    // Overflow: second press of 1 while its grant is held.
    bo_ready = 1'b0;
    bi = 4'b0010;
    tick(2);
    bi = '0;
    tick(2);
    bi = 4'b0010;
    tick(2);
    chk("ov_ovf_e6", 32'(ovf), 0);
    tick(1);
    chk("ov_ovf_e7", 32'(ovf), 1);
    chk("ov_pend", 32'(pend), 32'h2);
    chk("ov_id", 32'(bo_id), 1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("ov_clr", 32'(ovf), 0);

    // New edge lands on the accepting edge: set wins, no overflow, regrant.
    bi = '0;
    tick(2);
    bi = 4'b0010;
    tick(2);
    bo_ready = 1'b1;
    tick(1);
    chk("sw_bo", 32'(bo), 0);
    chk("sw_pend", 32'(pend), 32'h2);
    chk("sw_ovf", 32'(ovf), 0);
    tick(1);
    chk("sw_regrant", 32'(bo), 1);
    chk("sw_id", 32'(bo_id), 1);
    tick(1);
    chk("sw_pend_end", 32'(pend), 0);
    bi = '0;
    tick(4);

    // Reset during a held grant, then one grant for held bi[3].
    bo_ready = 1'b0;
    bi = 4'b1000;
    tick(4);
    chk("rg_bo_pre", 32'(bo), 1);
    #2 rst = 1'b1;
    #1;
    chk("rg_bo_async", 32'(bo), 0);
    chk("rg_pend_async", 32'(pend), 0);
    chk("rg_ovf_async", 32'(ovf), 0);
    tick(1);
    rst = 1'b0;
    bo_ready = 1'b1;
    ngr = 0;
    repeat (12) begin
      tick(1);
      if (bo) begin
        ngr++;
        chk("rg_id", 32'(bo_id), 3);
      end
    end
    chk("rg_grants", 32'(ngr), 1);
    bi = '0;
`endif

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
